// File: rtl/rbp_pkg.sv
// Shared constants, FSM state encoding and a small helper for the rbp host initiator.
package rbp_pkg;
    localparam int         RBP_DATA_W    = 16;
    localparam logic [3:0] RBP_CMD_SHIFT = 4'hF;
    localparam logic [3:0] RBP_CMD_NOP   = 4'h0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_REQ_HI,
        S_WAIT_HI,
        S_SETTLE,
        S_SAMPLE,
        S_WAIT_LO,
        S_DONE,
        S_LRST,
        S_TOUT
    } rbp_state_e;

    function automatic int rbp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/rbp_sync.sv
// W-bit two-flop synchroniser for signals arriving from the rbp responder.
module rbp_sync #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/rbp_host_initiator.sv
// rbp link initiator: four-phase req/ack handshake, serial shift beats on dat, then one command beat.
// Define RBP_HOST_TIMEOUT_EN for an ack timeout that reports rsp_err and auto-resets the link.
module rbp_host_initiator
    import rbp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  link_rst_req,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_code,
    input  logic [RBP_DATA_W-1:0] cmd_wdata,
    input  logic [4:0]            cmd_nbits,
    output logic                  rsp_valid,
    output logic [RBP_DATA_W-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rbp_req,
    input  logic                  rbp_ack,
    output logic                  rbp_rst,
    output logic                  rbp_dat,
    output logic [3:0]            rbp_cmd,
    input  logic [RBP_DATA_W-1:0] rbp_data
);
    localparam int DLY_W = $clog2(rbp_max(rbp_max(SETUP_CYCLES, SETTLE_CYCLES),
                                          rbp_max(RST_CYCLES, TIMEOUT_CYCLES)) + 1);

    rbp_state_e            r_state, w_state_nxt;
    logic [DLY_W-1:0]      r_dly;
    logic [4:0]            r_k, w_k_nxt, r_nbits, w_nbits_nxt;
    logic [3:0]            r_code, w_code_nxt;
    logic [RBP_DATA_W-1:0] r_wdata, w_wdata_nxt, w_shifted, r_cap, r_rsp_data;
    logic                  w_ack_s, w_beat, w_shift, w_last;
    logic [RBP_DATA_W-1:0] w_data_s;
    logic                  r_req, r_rst, r_dat;
    logic [3:0]            r_cmd;
`ifdef RBP_HOST_TIMEOUT_EN
    logic                  r_rsp_err;
`endif

    rbp_sync #(.W(1)) u_ack_sync (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_d(rbp_ack), .o_q(w_ack_s)
    );
    rbp_sync #(.W(RBP_DATA_W)) u_data_sync (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_d(rbp_data), .o_q(w_data_s)
    );

    assign w_last = (r_k == r_nbits);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_nbits_nxt = r_nbits;
        w_code_nxt  = r_code;
        w_wdata_nxt = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (link_rst_req) begin
                    w_state_nxt = S_LRST;
                end else if (cmd_valid) begin
                    w_state_nxt = S_SETUP;
                    w_k_nxt     = '0;
                    w_code_nxt  = cmd_code;
                    w_wdata_nxt = cmd_wdata;
                    w_nbits_nxt = (cmd_nbits > 5'd16) ? 5'd16 : cmd_nbits;
                end
            end
            S_SETUP:  if (r_dly == DLY_W'(SETUP_CYCLES - 1)) w_state_nxt = S_REQ_HI;
            S_REQ_HI: w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (w_ack_s) w_state_nxt = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
`ifdef RBP_HOST_TIMEOUT_EN
                else if (r_dly == DLY_W'(TIMEOUT_CYCLES - 1)) w_state_nxt = S_TOUT;
`endif
            end
            S_SETTLE: if (r_dly == DLY_W'(SETTLE_CYCLES - 1)) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!w_ack_s) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_k_nxt     = r_k + 5'd1;
                    end
                end
`ifdef RBP_HOST_TIMEOUT_EN
                else if (r_dly == DLY_W'(TIMEOUT_CYCLES - 1)) w_state_nxt = S_TOUT;
`endif
            end
            S_TOUT: w_state_nxt = S_DONE;
`ifdef RBP_HOST_TIMEOUT_EN
            S_DONE: w_state_nxt = r_rsp_err ? S_LRST : S_IDLE;
`else
            S_DONE: w_state_nxt = S_IDLE;
`endif
            S_LRST: if (r_dly == DLY_W'(RST_CYCLES - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Link pins are registered from the next state so they change cleanly with the state.
    assign w_beat    = w_state_nxt inside {S_SETUP, S_REQ_HI, S_WAIT_HI, S_SETTLE, S_SAMPLE, S_WAIT_LO};
    assign w_shift   = (w_k_nxt < w_nbits_nxt);
    assign w_shifted = w_wdata_nxt << w_k_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_dly      <= '0;
            r_k        <= '0;
            r_nbits    <= '0;
            r_code     <= '0;
            r_wdata    <= '0;
            r_cap      <= '0;
            r_rsp_data <= '0;
            r_req      <= 1'b0;
            r_rst      <= 1'b0;
            r_dat      <= 1'b0;
            r_cmd      <= RBP_CMD_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= (w_state_nxt != r_state) ? '0 : r_dly + 1'b1;
            r_k     <= w_k_nxt;
            r_nbits <= w_nbits_nxt;
            r_code  <= w_code_nxt;
            r_wdata <= w_wdata_nxt;
            r_req   <= w_state_nxt inside {S_REQ_HI, S_WAIT_HI, S_SETTLE, S_SAMPLE};
            r_rst   <= (w_state_nxt == S_LRST);
            r_cmd   <= !w_beat ? RBP_CMD_NOP : (w_shift ? RBP_CMD_SHIFT : w_code_nxt);
            r_dat   <= w_beat && w_shift && w_shifted[RBP_DATA_W-1];
            if (r_state == S_SAMPLE) r_cap <= w_data_s;
            if (r_state == S_WAIT_LO && w_state_nxt == S_DONE) r_rsp_data <= r_cap;
`ifdef RBP_HOST_TIMEOUT_EN
            if (r_state == S_TOUT) r_rsp_data <= '0;
`endif
        end
    end

`ifdef RBP_HOST_TIMEOUT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                                         r_rsp_err <= 1'b0;
        else if (r_state == S_TOUT)                          r_rsp_err <= 1'b1;
        else if (r_state == S_WAIT_LO && w_state_nxt == S_DONE) r_rsp_err <= 1'b0;
    end
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = (r_state == S_IDLE) && !link_rst_req && !sys_rst;
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_data  = r_rsp_data;
    assign rbp_req   = r_req;
    assign rbp_rst   = r_rst;
    assign rbp_dat   = r_dat;
    assign rbp_cmd   = r_cmd;
endmodule

// File: tb/tb_rbp_host_initiator.sv
// Bench for rbp_host_initiator: randomised-delay responder model, beat log and expected-beat model.
module tb_rbp_host_initiator;
    import rbp_pkg::*;

    localparam int SETUP = 2;
    localparam int SETTLE = 2;
    localparam int RSTC = 16;
`ifdef RBP_HOST_TIMEOUT_EN
    localparam int TOUT = 50;
`else
    localparam int TOUT = 65535;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        link_rst_req = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_code = '0;
    logic [15:0] cmd_wdata = '0;
    logic [4:0]  cmd_nbits = '0;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic        rbp_req, rbp_ack, rbp_rst, rbp_dat;
    logic [3:0]  rbp_cmd;
    logic [15:0] rbp_data;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] rsp_word = '0;
    logic [15:0] junk = '0;
    bit          no_ack = 1'b0;
    bit          stuck_arm = 1'b0;

    rbp_host_initiator #(
        .SETUP_CYCLES(SETUP), .SETTLE_CYCLES(SETTLE),
        .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .link_rst_req(link_rst_req),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_wdata(cmd_wdata), .cmd_nbits(cmd_nbits), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rbp_req(rbp_req), .rbp_ack(rbp_ack),
        .rbp_rst(rbp_rst), .rbp_dat(rbp_dat), .rbp_cmd(rbp_cmd), .rbp_data(rbp_data)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Responder: data bus follows the beat command; ack rises/falls D cycles after req edges.
    assign rbp_data = (rbp_cmd == RBP_CMD_SHIFT) ? junk : rsp_word;

    initial begin : responder
        int phase;
        int d;
        bit stuck_used;
        phase = 0; d = 0; stuck_used = 1'b0;
        rbp_ack = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            if (!stuck_arm) stuck_used = 1'b0;
            if (sys_rst) begin
                rbp_ack = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: begin
                        if (stuck_arm && !stuck_used && rbp_cmd != RBP_CMD_NOP) begin
                            rbp_ack = 1'b1;
                            stuck_used = 1'b1;
                        end
                        if (rbp_req) begin d = $urandom_range(0, 20); phase = 1; end
                    end
                    1: begin
                        if (!rbp_req && !rbp_ack) phase = 0;
                        else if (no_ack) phase = 1;
                        else if (d == 0) begin rbp_ack = 1'b1; phase = 2; end
                        else d--;
                    end
                    2: if (!rbp_req) begin d = $urandom_range(0, 20); phase = 3; end
                    default: begin
                        if (d == 0) begin rbp_ack = 1'b0; phase = 0; end
                        else d--;
                    end
                endcase
            end
        end
    end

    // Link monitor: beat log, setup time, beat stability, pulse lengths, rsp_valid count.
    logic [4:0] beats[$];
    int   rv_cnt = 0, rst_pulses = 0, rst_len = 0, last_rst_len = 0;
    int   req_len = 0, last_req_len = 0, setup_cnt = 0;
    logic prev_req = 1'b0;
    logic [4:0] prev_cd = '0, beat_cd = '0;
    bit   in_beat = 1'b0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            in_beat = 1'b0; setup_cnt = 0; prev_req = 1'b0; rst_len = 0; req_len = 0;
        end else begin
            if (rsp_valid) rv_cnt++;
            if (rbp_rst) begin
                rst_len++;
                chk("req_low_in_lrst", {31'd0, rbp_req}, 32'd0);
            end else if (rst_len != 0) begin
                last_rst_len = rst_len; rst_pulses++; rst_len = 0;
            end
            if (rbp_req) req_len++;
            else if (req_len != 0) begin last_req_len = req_len; req_len = 0; end
            if (in_beat) begin
                if (!rbp_req && !rbp_ack) in_beat = 1'b0;
                else chk("beat_stable", {27'd0, rbp_cmd, rbp_dat}, {27'd0, beat_cd});
            end
            if (rbp_req && !prev_req) begin
                chk("setup_before_req", {31'd0, setup_cnt >= SETUP}, 32'd1);
                beats.push_back({rbp_cmd, rbp_dat});
                beat_cd = {rbp_cmd, rbp_dat};
                in_beat = 1'b1;
            end
            if (rbp_req) setup_cnt = 0;
            else if ({rbp_cmd, rbp_dat} != prev_cd) setup_cnt = 1;
            else setup_cnt++;
            prev_cd = {rbp_cmd, rbp_dat};
            prev_req = rbp_req;
        end
    end

    task automatic issue(input string tag, input logic [3:0] code, input logic [15:0] w,
                         input logic [4:0] nb, input bit lrst);
        int n;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_code = code; cmd_wdata = w; cmd_nbits = nb;
        link_rst_req = lrst;
        if (lrst) begin
            #1;
            chk({tag, "_ready_drops"}, {31'd0, cmd_ready}, 32'd0);
            @(negedge sys_clk);
            link_rst_req = 1'b0;
            chk({tag, "_rst_high"}, {31'd0, rbp_rst}, 32'd1);
        end
        n = 0;
        while (!cmd_ready && n < 2000) begin @(negedge sys_clk); n++; end
        chk({tag, "_accept"}, {31'd0, cmd_ready}, 32'd1);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 3000) begin @(negedge sys_clk); n++; end
        chk({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
    endtask

    // Expected beats: min(nbits,16) shift beats carrying wdata MSB first, then the command beat.
    task automatic do_txn(input string tag, input logic [3:0] code, input logic [15:0] w,
                          input logic [4:0] nb, input logic [15:0] word, input bit lrst);
        int n, rv0, rs0, m;
        logic [4:0]  exp_b[$];
        logic [15:0] reasm;
        rsp_word = word;
        junk = 16'($urandom);
        beats.delete();
        rv0 = rv_cnt; rs0 = rst_pulses;
        issue(tag, code, w, nb, lrst);
        wait_rsp(tag);
        chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, word});
        chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
        repeat (2) @(negedge sys_clk);
        chk({tag, "_rsp_count"}, rv_cnt - rv0, 32'd1);
        chk({tag, "_lrst_count"}, rst_pulses - rs0, lrst ? 32'd1 : 32'd0);
        if (lrst) chk({tag, "_lrst_len"}, last_rst_len, RSTC);
        n = (nb > 16) ? 16 : int'(nb);
        exp_b.delete();
        for (int k = 0; k < n; k++) exp_b.push_back({RBP_CMD_SHIFT, w[15-k]});
        exp_b.push_back({code, 1'b0});
        chk({tag, "_nbeats"}, beats.size(), exp_b.size());
        m = (beats.size() < exp_b.size()) ? beats.size() : exp_b.size();
        for (int i = 0; i < m; i++) chk({tag, "_beat"}, {27'd0, beats[i]}, {27'd0, exp_b[i]});
        reasm = '0;
        for (int k = 0; k < n && k < beats.size(); k++) reasm = {reasm[14:0], beats[k][0]};
        if (n > 0) chk({tag, "_reassembled"}, {16'd0, reasm}, {16'd0, w >> (16 - n)});
    endtask

    initial begin : main
        int n, rv0, rs0;
        repeat (3) @(negedge sys_clk);
        chk("rst_req", {31'd0, rbp_req}, 32'd0);
        chk("rst_rst", {31'd0, rbp_rst}, 32'd0);
        chk("rst_dat", {31'd0, rbp_dat}, 32'd0);
        chk("rst_cmd", {28'd0, rbp_cmd}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

        do_txn("t1", 4'h3, 16'h0000, 5'd0, 16'hA55A, 1'b0);
        do_txn("t2", 4'h5, 16'hC001, 5'd16, 16'($urandom), 1'b0);
        do_txn("t3", 4'h6, 16'($urandom), 5'd4, 16'($urandom), 1'b1);

        stuck_arm = 1'b1;
        do_txn("t4_stuck", 4'h9, 16'($urandom), 5'd0, 16'($urandom), 1'b0);
        stuck_arm = 1'b0;
        do_txn("t4_toggle", 4'hA, 16'($urandom), 5'd3, 16'($urandom), 1'b0);
        do_txn("clamp", 4'h2, 16'($urandom), 5'd31, 16'($urandom), 1'b0);

        for (int i = 0; i < 6; i++)
            do_txn("rand", 4'($urandom_range(0, 14)), 16'($urandom),
                   5'($urandom_range(0, 20)), 16'($urandom), 1'b0);

        // Reset in the middle of beat 7 of a 16-bit shift.
        rsp_word = 16'h1234;
        beats.delete();
        issue("t6", 4'h4, 16'($urandom), 5'd16, 1'b0);
        n = 0;
        while (beats.size() < 7 && n < 3000) begin @(negedge sys_clk); n++; end
        chk("t6_reached_beat7", {31'd0, beats.size() >= 7}, 32'd1);
        rv0 = rv_cnt;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("t6_req", {31'd0, rbp_req}, 32'd0);
        chk("t6_cmd", {28'd0, rbp_cmd}, 32'd0);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (60) @(negedge sys_clk);
        chk("t6_no_rsp", rv_cnt - rv0, 32'd0);
        do_txn("t6_after", 4'h8, 16'($urandom), 5'd5, 16'($urandom), 1'b0);

`ifdef RBP_HOST_TIMEOUT_EN
        no_ack = 1'b1;
        rsp_word = 16'hBEEF;
        rs0 = rst_pulses;
        issue("t5", 4'h7, 16'h0000, 5'd0, 1'b0);
        wait_rsp("t5");
        chk("t5_err", {31'd0, rsp_err}, 32'd1);
        chk("t5_data", {16'd0, rsp_data}, 32'd0);
        // req is high for its one-cycle rise plus the full wait window.
        chk("t5_req_len", last_req_len, TOUT + 1);
        repeat (RSTC + 6) @(negedge sys_clk);
        chk("t5_lrst_count", rst_pulses - rs0, 32'd1);
        chk("t5_lrst_len", last_rst_len, RSTC);
        no_ack = 1'b0;
        do_txn("t5_after", 4'h1, 16'($urandom), 5'd2, 16'($urandom), 1'b0);
`else
        rs0 = rst_pulses;
        chk("no_spurious_lrst", rst_pulses - rs0, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
